// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
package cpu16_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int PC_STEP = 2;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hC000;

  // One prefetched instruction together with the address of its successor.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus2;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; flush wins over push and pop.
module fetch_queue
  import cpu16_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t     mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop & (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // Storage write; data is only meaningful once count covers the slot.
  always_ff @(posedge clk_i) begin
    if (push && !flush && !rst_i) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding fetches and
// feeds IF/ID from a prefetch queue, honouring stall and redirect.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                QDEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               DHZ_i,
  input  logic               CHZ_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] Instruction_o,
  output logic [ADDR_W-1:0]  PCadder1_sum_o,
  output logic               instr_valid_o
);

  import cpu16_pkg::*;

  localparam int               CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              outstanding_q;
  logic              drop_q;

  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  // Issue only when the queue can take the response even if nothing pops.
  assign issue = !rst_i && !CHZ_i && !outstanding_q && (count < QDEPTH_C);
  assign resp  = imem_valid_i && outstanding_q;
  assign push  = resp && !drop_q && !CHZ_i;
  assign pop   = instr_valid_o && !DHZ_i && !CHZ_i;

  assign push_data.instr    = imem_data_i;
  assign push_data.pc_plus2 = req_addr_q + ADDR_W'(PC_STEP);

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  assign instr_valid_o  = (count != '0);
  assign Instruction_o  = instr_valid_o ? head.instr : NOP_INSTR;
  assign PCadder1_sum_o = instr_valid_o ? head.pc_plus2 : '0;

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (CHZ_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // PC, in-flight tracking and stale-response drop bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (CHZ_i) begin
        pc_q <= branch_target_i;
        // A response still on its way belongs to the old path.
        if (outstanding_q && !imem_valid_i) drop_q <= 1'b1;
      end else if (issue) begin
        pc_q          <= pc_q + ADDR_W'(PC_STEP);
        req_addr_q    <= pc_q;
        outstanding_q <= 1'b1;
      end
      if (resp) begin
        outstanding_q <= 1'b0;
        if (drop_q) drop_q <= 1'b0;
      end
    end
  end

endmodule
